// File: rtl/ysyx_22040383_pipe_stage_reg_pkg.sv
// Shared defaults for pipeline stage registers.
// Holds the stage payload layout, default width/bubble and helpers.
package ysyx_22040383_pipe_stage_reg_pkg;

    // IF/ID payload layout: pc in [63:32], inst in [31:0].
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } if_id_t;

    localparam int PSR_WIDTH = $bits(if_id_t);

    // Bubble payload shown by an empty or flushed stage.
    localparam logic [PSR_WIDTH-1:0] PSR_BUBBLE = '0;

    function automatic logic [1:0] occ_count(
        input logic a,
        input logic b
    );
        return {1'b0, a} + {1'b0, b};
    endfunction

endpackage

// File: rtl/ysyx_22040383_pipe_stage_reg_slot.sv
// One storage slot of a stage register: valid bit + payload.
// Ports: i_clk; i_clear (priority, loads BUBBLE); i_load, i_data; o_valid, o_data.
module ysyx_22040383_pipe_slot
    import ysyx_22040383_pipe_stage_reg_pkg::*;
#(
    parameter int                WIDTH  = PSR_WIDTH,
    parameter logic [WIDTH-1:0]  BUBBLE = '0
) (
    input  logic             i_clk,
    input  logic             i_clear,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data
);

    logic             r_valid;
    logic [WIDTH-1:0] r_data;

    // Clearing writes BUBBLE so o_data needs no output mux.
    always_ff @(posedge i_clk) begin
        if (i_clear) begin
            r_valid <= 1'b0;
            r_data  <= BUBBLE;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule

// File: rtl/ysyx_22040383_pipe_stage_reg.sv
// Valid/ready pipeline stage register, optional two-entry skid buffer.
// Ports: sys_clk, sys_rst (sync, high), flush; in_valid/in_data/in_ready;
// out_valid/out_data/out_ready; occupancy (beats held).
module ysyx_22040383_pipe_stage_reg
    import ysyx_22040383_pipe_stage_reg_pkg::*;
#(
    parameter int               WIDTH  = PSR_WIDTH,
    parameter int               SKID   = 1,
    parameter logic [WIDTH-1:0] BUBBLE = WIDTH'(PSR_BUBBLE)
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic [1:0]       occupancy
);

    logic             w_kill;
    logic             w_acc;
    logic             w_rel;
    logic             w_in_ready;
    logic             w_m_valid;
    logic [WIDTH-1:0] w_m_data;
    logic             w_m_load;
    logic             w_m_clear;
    logic [WIDTH-1:0] w_m_din;
    logic             w_s_valid;

    // Reset and flush both empty the stage; reset also wins over handshakes.
    assign w_kill = sys_rst || flush;
    assign w_acc  = in_valid && w_in_ready;
    assign w_rel  = w_m_valid && out_ready;

    ysyx_22040383_pipe_slot #(
        .WIDTH  (WIDTH),
        .BUBBLE (BUBBLE)
    ) u_main (
        .i_clk   (sys_clk),
        .i_clear (w_m_clear),
        .i_load  (w_m_load),
        .i_data  (w_m_din),
        .o_valid (w_m_valid),
        .o_data  (w_m_data)
    );

    generate
        if (SKID != 0) begin : g_skid
            logic             w_m_free;
            logic             w_s_load;
            logic             w_s_clear;
            logic [WIDTH-1:0] w_s_data;

            // Main empties or drains this edge.
            assign w_m_free = !w_m_valid || w_rel;

            // Skid entry (older) refills main before a new beat does.
            assign w_m_load  = !w_kill && w_m_free && (w_s_valid || w_acc);
            assign w_m_din   = w_s_valid ? w_s_data : in_data;
            assign w_m_clear = w_kill || (w_rel && !w_s_valid && !w_acc);

            // New beat parks in skid only when main is held.
            assign w_s_load  = !w_kill && w_acc && w_m_valid && !w_rel;
            assign w_s_clear = w_kill || (w_s_valid && w_rel);

            // Skid valid is a flop, so in_ready is registered.
            assign w_in_ready = !w_s_valid;

            ysyx_22040383_pipe_slot #(
                .WIDTH  (WIDTH),
                .BUBBLE (BUBBLE)
            ) u_skid (
                .i_clk   (sys_clk),
                .i_clear (w_s_clear),
                .i_load  (w_s_load),
                .i_data  (in_data),
                .o_valid (w_s_valid),
                .o_data  (w_s_data)
            );
        end else begin : g_single
            assign w_in_ready = !w_m_valid || out_ready;
            assign w_m_load   = !w_kill && w_acc;
            assign w_m_din    = in_data;
            assign w_m_clear  = w_kill || (w_rel && !w_acc);
            assign w_s_valid  = 1'b0;
        end
    endgenerate

    assign in_ready  = w_in_ready;
    assign out_valid = w_m_valid;
    assign out_data  = w_m_data;
    assign occupancy = occ_count(w_m_valid, w_s_valid);

endmodule

// File: tb/tb_ysyx_22040383_pipe_stage_reg.sv
// Bench for ysyx_22040383_pipe_stage_reg: SKID=1 and SKID=0 instances
// checked by vector table, directed sequences and a queue model.
module tb_ysyx_22040383_pipe_stage_reg;

    localparam logic [63:0] BUB1 = 64'h0;
    localparam logic [63:0] BUB0 = 64'hBBBB_0000_0000_BBBB;

    logic        sys_clk;
    logic        rst1, fl1, iv1, or1;
    logic [63:0] id1;
    logic        rdy1, ov1;
    logic [63:0] od1;
    logic [1:0]  oc1;
    logic        rst0, fl0, iv0, or0;
    logic [63:0] id0;
    logic        rdy0, ov0;
    logic [63:0] od0;
    logic [1:0]  oc0;

    int n_chk;
    int n_fail;

    logic [63:0] q1[$];
    logic [63:0] q0[$];

    ysyx_22040383_pipe_stage_reg #(
        .WIDTH  (64),
        .SKID   (1),
        .BUBBLE (BUB1)
    ) dut1 (
        .sys_clk   (sys_clk),
        .sys_rst   (rst1),
        .flush     (fl1),
        .in_valid  (iv1),
        .in_data   (id1),
        .in_ready  (rdy1),
        .out_valid (ov1),
        .out_data  (od1),
        .out_ready (or1),
        .occupancy (oc1)
    );

    ysyx_22040383_pipe_stage_reg #(
        .WIDTH  (64),
        .SKID   (0),
        .BUBBLE (BUB0)
    ) dut0 (
        .sys_clk   (sys_clk),
        .sys_rst   (rst0),
        .flush     (fl0),
        .in_valid  (iv0),
        .in_data   (id0),
        .in_ready  (rdy0),
        .out_valid (ov0),
        .out_data  (od0),
        .out_ready (or0),
        .occupancy (oc0)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
        end
    endtask

    // Capacity 2 with ready from state (skid), or capacity 1 with
    // ready = empty or downstream taking the held beat.
    function automatic bit exp_rdy(input int k, input bit o);
        if (k == 1) return q1.size() < 2;
        return (q0.size() == 0) || o;
    endfunction

    task automatic model_edge(input int k, input bit r, input bit f,
                              input bit v, input logic [63:0] d, input bit o);
        logic [63:0] t[$];
        bit acc, rel;
        t = (k == 1) ? q1 : q0;
        acc = v && exp_rdy(k, o);
        rel = (t.size() > 0) && o;
        if (r || f) begin
            t.delete();
        end else begin
            if (rel) void'(t.pop_front());
            if (acc) t.push_back(d);
        end
        if (k == 1) q1 = t;
        else q0 = t;
    endtask

    task automatic check_outs();
        chk("ov1", {63'b0, ov1}, {63'b0, q1.size() > 0});
        chk("od1", od1, (q1.size() > 0) ? q1[0] : BUB1);
        chk("oc1", {62'b0, oc1}, 64'(q1.size()));
        chk("ov0", {63'b0, ov0}, {63'b0, q0.size() > 0});
        chk("od0", od0, (q0.size() > 0) ? q0[0] : BUB0);
        chk("oc0", {62'b0, oc0}, 64'(q0.size()));
    endtask

    task automatic step();
        #1;
        chk("rdy1_pre", {63'b0, rdy1}, {63'b0, exp_rdy(1, or1)});
        chk("rdy0_pre", {63'b0, rdy0}, {63'b0, exp_rdy(0, or0)});
        model_edge(1, rst1, fl1, iv1, id1, or1);
        model_edge(0, rst0, fl0, iv0, id0, or0);
        @(posedge sys_clk);
        #1;
        check_outs();
    endtask

    task automatic drive_both(input bit r, input bit f, input bit v,
                              input logic [63:0] d, input bit o);
        rst1 = r; fl1 = f; iv1 = v; id1 = d; or1 = o;
        rst0 = r; fl0 = f; iv0 = v; id0 = d; or0 = o;
    endtask

    typedef struct {
        bit          rst;
        bit          fl;
        bit          iv;
        logic [63:0] d;
        bit          o;
        bit          e_v;
        logic [63:0] e_d;
        logic [1:0]  e_occ;
        bit          e_rdy;
    } vec_t;

    vec_t tbl[21];

    initial begin
        n_chk  = 0;
        n_fail = 0;
        drive_both(1'b1, 1'b0, 1'b0, 64'h0, 1'b0);
        @(posedge sys_clk);
        #1;
        q1.delete();
        q0.delete();

        // Expected SKID=1 outputs after each edge.
        tbl[0]  = '{1, 0, 0, 64'h00, 0, 0, 64'h00, 2'd0, 1};
        tbl[1]  = '{0, 0, 1, 64'hA5, 1, 1, 64'hA5, 2'd1, 1};
        tbl[2]  = '{0, 0, 0, 64'h00, 1, 0, 64'h00, 2'd0, 1};
        tbl[3]  = '{0, 0, 1, 64'h11, 0, 1, 64'h11, 2'd1, 1};
        tbl[4]  = '{0, 0, 1, 64'h22, 0, 1, 64'h11, 2'd2, 0};
        tbl[5]  = '{0, 0, 1, 64'h99, 0, 1, 64'h11, 2'd2, 0};
        tbl[6]  = '{0, 0, 0, 64'h00, 1, 1, 64'h22, 2'd1, 1};
        tbl[7]  = '{0, 0, 0, 64'h00, 1, 0, 64'h00, 2'd0, 1};
        tbl[8]  = '{0, 0, 1, 64'h44, 0, 1, 64'h44, 2'd1, 1};
        tbl[9]  = '{0, 0, 1, 64'h55, 0, 1, 64'h44, 2'd2, 0};
        tbl[10] = '{0, 1, 1, 64'h33, 0, 0, 64'h00, 2'd0, 1};
        tbl[11] = '{0, 0, 0, 64'h00, 1, 0, 64'h00, 2'd0, 1};
        tbl[12] = '{0, 0, 1, 64'h66, 0, 1, 64'h66, 2'd1, 1};
        tbl[13] = '{0, 0, 1, 64'h77, 0, 1, 64'h66, 2'd2, 0};
        tbl[14] = '{1, 0, 0, 64'h00, 0, 0, 64'h00, 2'd0, 1};
        tbl[15] = '{0, 0, 0, 64'h00, 1, 0, 64'h00, 2'd0, 1};
        tbl[16] = '{0, 0, 1, 64'h88, 0, 1, 64'h88, 2'd1, 1};
        tbl[17] = '{0, 0, 1, 64'hC3, 1, 1, 64'hC3, 2'd1, 1};
        tbl[18] = '{0, 0, 0, 64'h00, 1, 0, 64'h00, 2'd0, 1};
        tbl[19] = '{0, 0, 1, 64'h12, 0, 1, 64'h12, 2'd1, 1};
        tbl[20] = '{0, 1, 0, 64'h00, 1, 0, 64'h00, 2'd0, 1};

        for (int i = 0; i < 21; i++) begin
            drive_both(tbl[i].rst, tbl[i].fl, tbl[i].iv, tbl[i].d, tbl[i].o);
            step();
            chk($sformatf("tbl%0d_v", i), {63'b0, ov1}, {63'b0, tbl[i].e_v});
            chk($sformatf("tbl%0d_d", i), od1, tbl[i].e_d);
            chk($sformatf("tbl%0d_occ", i), {62'b0, oc1}, {62'b0, tbl[i].e_occ});
            chk($sformatf("tbl%0d_rdy", i), {63'b0, rdy1}, {63'b0, tbl[i].e_rdy});
        end

        // Streaming 1..100 with no bubbles on either variant.
        drive_both(1'b1, 1'b0, 1'b0, 64'h0, 1'b0);
        step();
        for (int i = 1; i <= 100; i++) begin
            drive_both(1'b0, 1'b0, 1'b1, 64'(i), 1'b1);
            step();
            chk("stream0_v", {63'b0, ov0}, 64'd1);
            chk("stream0_d", od0, 64'(i));
            chk("stream1_d", od1, 64'(i));
        end
        drive_both(1'b0, 1'b0, 1'b0, 64'h0, 1'b1);
        step();
        chk("stream0_drain", od0, BUB0);

        // Independent random traffic on both instances.
        for (int c = 0; c < 10000; c++) begin
            rst1 = ($urandom_range(0, 999) == 0);
            fl1  = ($urandom_range(0, 63) == 0);
            iv1  = $urandom_range(0, 1);
            id1  = {$urandom, $urandom};
            or1  = ($urandom_range(0, 3) != 0);
            rst0 = ($urandom_range(0, 999) == 0);
            fl0  = ($urandom_range(0, 63) == 0);
            iv0  = ($urandom_range(0, 3) != 0);
            id0  = {$urandom, $urandom};
            or0  = $urandom_range(0, 1);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/ysyx_22040383_pipe_stage_reg.md
YSYX_22040383_PIPE_STAGE_REG -- requirements
Module: ysyx_22040383_pipe_stage_reg

Interface
REQ-001 SHALL have parameter WIDTH, default 64, payload width in bits.
REQ-002 SHALL have parameter SKID, default 1; 1 = two-entry skid register, 0 = single entry with combinational ready.
REQ-003 SHALL have parameter BUBBLE, WIDTH bits, default 0; the payload shown when the stage is empty or flushed.
REQ-004 SHALL run on one clock; reset is synchronous and active-high.
REQ-005 sys_clk  input  1  clock; all state changes on its rising edge.
REQ-006 sys_rst  input  1  synchronous, active-high reset.
REQ-007 flush  input  1  kill all held beats (control hazard).
REQ-008 in_valid  input  1  upstream beat present.
REQ-009 in_data  input  WIDTH  upstream payload.
REQ-010 in_ready  output  1  stage can accept a beat this cycle.
REQ-011 out_valid  output  1  downstream beat present.
REQ-012 out_data  output  WIDTH  downstream payload.
REQ-013 out_ready  input  1  downstream accepts this cycle.
REQ-014 occupancy  output  2  beats held, 0..2 (0..1 when SKID=0).

Function
REQ-015 SHALL accept a beat when in_valid && in_ready at a rising edge, and release one when out_valid && out_ready.
REQ-016 SHALL present an accepted beat on out_data/out_valid exactly one cycle after acceptance when the stage was empty or draining.
REQ-017 SHALL keep out_data and out_valid stable while out_valid && !out_ready.
REQ-018 SHALL drive out_data = BUBBLE whenever out_valid = 0.
REQ-019 SKID=1: in_ready SHALL be registered and equal !skid_full; main entry full, out stalled, new beat accepted -> beat goes to skid entry and in_ready drops next cycle.
REQ-020 SKID=1: when main drains with skid full, skid SHALL move to main the same edge, and in_ready rises next cycle.
REQ-021 SKID=1: simultaneous accept and release with main full and skid empty SHALL load the new beat into main, skid stays empty.
REQ-022 SKID=0: in_ready SHALL equal !out_valid || out_ready combinationally; simultaneous accept and release replaces the entry with no bubble.
REQ-023 Beats SHALL leave in acceptance order; none duplicated or dropped except by flush.
REQ-024 flush SHALL clear both entries at the edge, giving out_valid=0, out_data=BUBBLE, occupancy=0 next cycle; a beat offered that same cycle is discarded, a release that same cycle still counts.
REQ-025 occupancy SHALL equal the number of valid entries after each edge.
REQ-026 All outputs SHALL have no combinational path from in_* to out_*.

Reset
REQ-027 sys_rst SHALL take priority over flush and handshakes.
REQ-028 After reset: out_valid=0, out_data=BUBBLE, occupancy=0, in_ready=1 (SKID=1 registered; SKID=0 follows REQ-022), skid entry invalid.
REQ-029 Reset asserted mid-stall SHALL discard held beats with no downstream release.

Structure
REQ-030 Default WIDTH and BUBBLE encodings SHALL live in the shared para.v define file; per-stage payload layouts are defined there as bit ranges.
REQ-031 One sub-module SHALL be used: ysyx_22040383_pipe_slot (valid + WIDTH-bit data register with load/clear), instantiated once for main and, when SKID=1, once for skid.
REQ-032 Target size 120-250 lines RTL; generate block selects SKID variant.

Verification
REQ-033 Reset, then in_valid=1, in_data=0xA5, out_ready=1 -> next cycle out_valid=1, out_data=0xA5, occupancy=1.
REQ-034 SKID=1, out_ready=0, send 0x11 then 0x22 -> occupancy=2, in_ready=0, out_data=0x11 held; raise out_ready -> 0x11 then 0x22 on successive cycles, in_ready returns 1.
REQ-035 Occupancy 2, flush=1 with in_valid=1 in_data=0x33 -> next cycle out_valid=0, out_data=BUBBLE (e.g. 0x0), occupancy=0, 0x33 never appears.
REQ-036 SKID=0, continuous in_valid and out_ready, data 1..100 -> one beat per cycle, outputs 1..100 in order, no bubbles.
REQ-037 Random in_valid/out_ready 10000 cycles, scoreboard -> order preserved, no loss, out_data=BUBBLE whenever out_valid=0.
REQ-038 sys_rst asserted during stall at occupancy 2 -> next cycle occupancy=0, out_valid=0, no beat released.
